// File: rtl/rota_pkg.sv
// Shared constants and FSM state type for the route collector.
// Holds route width, counter width, state enum and default timeout.
package rota_pkg;

    localparam int ROTA_W  = 6;
    localparam int SAYAC_W = 3;
    localparam int ZAMAN_ASIMI_VARSAYILAN = 255;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        TOPLA = 2'd1,
        HAZIR = 2'd2
    } durum_t;

endpackage

// File: rtl/rota_kaydirici.sv
// Route shift/count datapath: places each bit MSB-first, counts bits.
// Ports: clk, rst_n, temizle (clear), yukle (load), bit_deger -> rota, sayac.
module rota_kaydirici
    import rota_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               temizle,
    input  logic               yukle,
    input  logic               bit_deger,
    output logic [ROTA_W-1:0]  rota,
    output logic [SAYAC_W-1:0] sayac
);

    // Bit lands at position 5-sayac; unused positions stay 0, so OR-in works.
    logic [ROTA_W-1:0] yeni_bit;
    assign yeni_bit = {bit_deger, {(ROTA_W-1){1'b0}}} >> sayac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rota  <= '0;
            sayac <= '0;
        end else if (temizle) begin
            rota  <= '0;
            sayac <= '0;
        end else if (yukle && (sayac < SAYAC_W'(ROTA_W))) begin
            rota  <= rota | yeni_bit;
            sayac <= sayac + SAYAC_W'(1);
        end
    end

endmodule

// File: rtl/rota_toplayici.sv
// Serial route collector: gathers 6 bits, offers them with valid/accept.
// Ports: bit_gecerli/bit_deger/iptal in, rota/rota_gecerli/rota_al out,
// zaman_asimi pulse. Macro ROTA_ZAMAN_ASIMI_EN enables the idle timeout.
module rota_toplayici
    import rota_pkg::*;
#(
    parameter int ZAMAN_ASIMI = ZAMAN_ASIMI_VARSAYILAN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_gecerli,
    input  logic              bit_deger,
    input  logic              iptal,
    output logic [ROTA_W-1:0] rota,
    output logic              rota_gecerli,
    input  logic              rota_al,
    output logic              zaman_asimi
);

    durum_t             durum;
    logic [SAYAC_W-1:0] sayac;
    logic               aktarim;
    logic               yukle;
    logic               temizle;
    logic               zaman_doldu;

    assign aktarim = rota_gecerli && rota_al;

    // iptal beats a same-cycle bit while collecting
    assign yukle = bit_gecerli &&
                   ((durum == BOS) || ((durum == TOPLA) && !iptal));

    assign temizle = ((durum == TOPLA) && iptal) ||
                     ((durum == HAZIR) && aktarim) ||
                     zaman_doldu;

`ifdef ROTA_ZAMAN_ASIMI_EN
    logic [7:0] bos_sayac;

    assign zaman_doldu = (durum == TOPLA) && !iptal && !bit_gecerli &&
                         (bos_sayac == 8'(ZAMAN_ASIMI - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bos_sayac   <= '0;
            zaman_asimi <= 1'b0;
        end else begin
            zaman_asimi <= zaman_doldu;
            if ((durum != TOPLA) || yukle || zaman_doldu)
                bos_sayac <= '0;
            else
                bos_sayac <= bos_sayac + 8'd1;
        end
    end
`else
    assign zaman_doldu = 1'b0;
    assign zaman_asimi = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum        <= BOS;
            rota_gecerli <= 1'b0;
        end else begin
            unique case (durum)
                BOS: begin
                    if (bit_gecerli)
                        durum <= TOPLA;
                end
                TOPLA: begin
                    if (iptal || zaman_doldu) begin
                        durum <= BOS;
                    end else if (bit_gecerli &&
                                 (sayac == SAYAC_W'(ROTA_W - 1))) begin
                        durum        <= HAZIR;
                        rota_gecerli <= 1'b1;
                    end
                end
                HAZIR: begin
                    if (aktarim) begin
                        durum        <= BOS;
                        rota_gecerli <= 1'b0;
                    end
                end
                default: begin
                    durum        <= BOS;
                    rota_gecerli <= 1'b0;
                end
            endcase
        end
    end

    rota_kaydirici u_kaydirici (
        .clk       (clk),
        .rst_n     (rst_n),
        .temizle   (temizle),
        .yukle     (yukle),
        .bit_deger (bit_deger),
        .rota      (rota),
        .sayac     (sayac)
    );

endmodule

// File: tb/tb_rota_toplayici.sv
// Directed bench for rota_toplayici: collection, handshake, abort, reset,
// and idle timeout (behaviour depends on ROTA_ZAMAN_ASIMI_EN).
module tb_rota_toplayici;
    import rota_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_gecerli = 1'b0;
    logic       bit_deger = 1'b0;
    logic       iptal = 1'b0;
    logic [5:0] rota;
    logic       rota_gecerli;
    logic       rota_al = 1'b0;
    logic       zaman_asimi;

    int vec = 0;
    int hata = 0;

    always #5 clk = ~clk;

    rota_toplayici #(.ZAMAN_ASIMI(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_gecerli  (bit_gecerli),
        .bit_deger    (bit_deger),
        .iptal        (iptal),
        .rota         (rota),
        .rota_gecerli (rota_gecerli),
        .rota_al      (rota_al),
        .zaman_asimi  (zaman_asimi)
    );

    task automatic bit_gonder(input logic b);
        @(negedge clk);
        bit_gecerli = 1'b1;
        bit_deger   = b;
        @(negedge clk);
        bit_gecerli = 1'b0;
        bit_deger   = 1'b0;
    endtask

    task automatic kontrol(input string ad, input logic [5:0] r,
                           input logic g, input durum_t d);
        vec++;
        if (rota !== r || rota_gecerli !== g || dut.durum !== d) begin
            hata++;
            $display("FAIL %s: rota=%b gecerli=%b durum=%0d, want %b %b %0d",
                     ad, rota, rota_gecerli, dut.durum, r, g, d);
        end
    endtask

    task automatic aktar;
        @(negedge clk);
        rota_al = 1'b1;
        @(negedge clk);
        rota_al = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        bit_gecerli = 1'b1;
        bit_deger   = 1'b1;
        repeat (2) @(negedge clk);
        kontrol("reset_state", 6'b0, 1'b0, BOS);
        bit_gecerli = 1'b0;
        bit_deger   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        kontrol("reset_release_idle", 6'b0, 1'b0, BOS);
        vec++;
        if (zaman_asimi !== 1'b0) begin
            hata++;
            $display("FAIL reset_timeout: got %b want 0", zaman_asimi);
        end
    endtask

    task automatic test_art_arda;
        logic [5:0] b;
        b = 6'b111000;
        for (int i = 5; i >= 0; i--) begin
            bit_gonder(b[i]);
            if (i == 4) kontrol("b2b_partial2", 6'b110000, 1'b0, TOPLA);
            if (i == 1) kontrol("b2b_partial5", 6'b111000, 1'b0, TOPLA);
        end
        kontrol("b2b_done", 6'b111000, 1'b1, HAZIR);
        bit_gonder(1'b1);
        bit_gonder(1'b1);
        repeat (2) @(negedge clk);
        kontrol("b2b_hold", 6'b111000, 1'b1, HAZIR);
        aktar();
        kontrol("b2b_after_xfer", 6'b0, 1'b0, BOS);
    endtask

    task automatic test_aktarim;
        logic [5:0] b;
        b = 6'b100101;
        for (int i = 5; i >= 0; i--) begin
            bit_gonder(b[i]);
            if (i != 0) repeat (3) @(negedge clk);
        end
        kontrol("gap_done", 6'b100101, 1'b1, HAZIR);
        @(negedge clk);
        rota_al     = 1'b1;
        bit_gecerli = 1'b1;
        bit_deger   = 1'b1;
        @(negedge clk);
        rota_al     = 1'b0;
        bit_gecerli = 1'b0;
        bit_deger   = 1'b0;
        kontrol("xfer_drop_bit", 6'b0, 1'b0, BOS);
        @(negedge clk);
        kontrol("xfer_idle", 6'b0, 1'b0, BOS);
    endtask

    task automatic test_iptal;
        logic [5:0] b;
        @(negedge clk);
        iptal = 1'b1;
        @(negedge clk);
        iptal = 1'b0;
        kontrol("iptal_bos", 6'b0, 1'b0, BOS);
        bit_gonder(1'b1);
        bit_gonder(1'b0);
        bit_gonder(1'b1);
        kontrol("iptal_pre", 6'b101000, 1'b0, TOPLA);
        @(negedge clk);
        iptal       = 1'b1;
        bit_gecerli = 1'b1;
        bit_deger   = 1'b1;
        @(negedge clk);
        iptal       = 1'b0;
        bit_gecerli = 1'b0;
        bit_deger   = 1'b0;
        kontrol("iptal_wins", 6'b0, 1'b0, BOS);
        b = 6'b100011;
        for (int i = 5; i >= 0; i--) bit_gonder(b[i]);
        kontrol("iptal_recollect", 6'b100011, 1'b1, HAZIR);
        @(negedge clk);
        iptal = 1'b1;
        @(negedge clk);
        iptal = 1'b0;
        kontrol("iptal_hazir", 6'b100011, 1'b1, HAZIR);
        aktar();
    endtask

    task automatic test_reset_ortasi;
        logic [5:0] b;
        bit_gonder(1'b1);
        bit_gonder(1'b1);
        bit_gonder(1'b0);
        bit_gonder(1'b1);
        #2 rst_n = 1'b0;
        #1 kontrol("async_rst_mid", 6'b0, 1'b0, BOS);
        @(negedge clk);
        rst_n = 1'b1;
        b = 6'b010101;
        for (int i = 5; i >= 0; i--) bit_gonder(b[i]);
        kontrol("post_rst_clean", 6'b010101, 1'b1, HAZIR);
        #2 rst_n = 1'b0;
        #1 kontrol("async_rst_hazir", 6'b0, 1'b0, BOS);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kontrol("post_rst_hazir", 6'b0, 1'b0, BOS);
        bit_gonder(1'b0);
        kontrol("post_rst_first", 6'b0, 1'b0, TOPLA);
        @(negedge clk);
        iptal = 1'b1;
        @(negedge clk);
        iptal = 1'b0;
    endtask

    task automatic test_zaman_asimi;
        int darbe;
        darbe = 0;
        bit_gonder(1'b1);
        bit_gonder(1'b1);
`ifdef ROTA_ZAMAN_ASIMI_EN
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (zaman_asimi === 1'b1) darbe++;
            if (i == 10) begin
                vec++;
                if (zaman_asimi !== 1'b1) begin
                    hata++;
                    $display("FAIL tmo_edge: got %b want 1", zaman_asimi);
                end
            end
        end
        vec++;
        if (darbe != 1) begin
            hata++;
            $display("FAIL tmo_pulses: got %0d want 1", darbe);
        end
        kontrol("tmo_state", 6'b0, 1'b0, BOS);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (zaman_asimi !== 1'b0) darbe++;
        end
        vec++;
        if (darbe != 0) begin
            hata++;
            $display("FAIL tmo_tied: got %0d pulses want 0", darbe);
        end
        kontrol("tmo_wait", 6'b110000, 1'b0, TOPLA);
        bit_gonder(1'b0);
        bit_gonder(1'b1);
        bit_gonder(1'b0);
        bit_gonder(1'b1);
        kontrol("tmo_resume", 6'b110101, 1'b1, HAZIR);
        aktar();
`endif
    endtask

    initial begin
        test_reset();
        test_art_arda();
        test_aktarim();
        test_iptal();
        test_reset_ortasi();
        test_zaman_asimi();
        $display("== %0d vectors applied, %0d miscompares ==", vec, hata);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1);
    end

endmodule
